counter_irq_ctrl: RTL

Timer event and interrupt controller sitting directly downstream of the three-channel counter. It takes the counters' terminal-count outputs (`counter0_OUT`..`counter2_OUT`, each generated in its own `clk0`..`clk2` domain) and synchronises them into the CPU clock domain. It edge-detects them into per-channel pending/overrun flags and saturating event counts, and raises a maskable level interrupt to the CPU. The CPU reads and clears the flags through a 4-word register window.

---
 rtl/counter_irq_pkg.sv | 10 +
 rtl/counter_irq_ctrl_sync_edge.sv | 27 ++
 rtl/counter_irq_ctrl.sv | 97 +++++++++
 3 files changed

// File: rtl/counter_irq_pkg.sv
// counter_irq_pkg: register map, field offsets and arm FSM state shared by the timer interrupt controller
package counter_irq_pkg;
  localparam logic [1:0] ADDR_STATUS = 2'd0;
  localparam logic [1:0] ADDR_CTRL   = 2'd1;
  localparam logic [1:0] ADDR_EVCNT  = 2'd2;
  localparam logic [1:0] ADDR_RAW    = 2'd3;
  localparam int OVR_LSB = 8;
  localparam int POL_LSB = 8;
  typedef enum logic {DISARMED = 1'b0, ARMED = 1'b1} arm_state_t;
endpackage

// File: rtl/counter_irq_ctrl_sync_edge.sv
// cnt_sync_edge: synchronises one terminal-count level into clk and flags its active edge
module cnt_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  input  logic pol,
  input  logic armed,
  output logic sync,
  output logic evt
);
  logic [SYNC_STAGES-1:0] ff;
  logic prev;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ff <= '0;
      prev <= 1'b0;
    end else begin
      ff <= {ff[SYNC_STAGES-2:0], din};
      prev <= ff[SYNC_STAGES-1];
    end
  end
  assign sync = ff[SYNC_STAGES-1];
  // Comparing both samples after polarity inversion keeps a bare polarity flip from looking like an edge
  assign evt = armed & (sync ^ pol) & ~(prev ^ pol);
endmodule

// File: rtl/counter_irq_ctrl.sv
// counter_irq_ctrl: per-channel pending/overrun flags, saturating event counts and maskable irq for counter outputs
module counter_irq_ctrl
  import counter_irq_pkg::*;
#(
  parameter int NCH = 3,
  parameter int SYNC_STAGES = 2,
  parameter int EVC_W = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic [NCH-1:0] cnt_out,
  input  logic reg_we,
  input  logic [1:0] reg_addr,
  input  logic [31:0] reg_wdata,
  output logic [31:0] reg_rdata,
  output logic irq
);
  localparam int AW = $clog2(SYNC_STAGES + 2);
  arm_state_t state;
  logic [AW-1:0] arm_cnt;
  logic armed;
  logic [NCH-1:0] evt, sync, pending, overrun, enable, pol;
  logic [NCH-1:0] pending_nx, overrun_nx, clr_p, clr_o;
  logic [NCH-1:0][EVC_W-1:0] evcnt, evcnt_nx;
  logic wr_status, wr_ctrl, wr_evcnt;
  logic [31:0] status_w, ctrl_w;
  logic unused_ok;
  assign unused_ok = ^reg_wdata;
  for (genvar c = 0; c < NCH; c++) begin : g_ch
    cnt_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_ch (
      .clk(clk),
      .rst(rst),
      .din(cnt_out[c]),
      .pol(pol[c]),
      .armed(armed),
      .sync(sync[c]),
      .evt(evt[c])
    );
  end
  // Hold events off until inputs already high at reset release have propagated into prev
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= DISARMED;
      arm_cnt <= '0;
      armed <= 1'b0;
    end else if (state == DISARMED) begin
      if (arm_cnt == AW'(SYNC_STAGES)) begin
        state <= ARMED;
        armed <= 1'b1;
      end else begin
        arm_cnt <= arm_cnt + AW'(1);
      end
    end
  end
  assign wr_status = reg_we && reg_addr == ADDR_STATUS;
  assign wr_ctrl = reg_we && reg_addr == ADDR_CTRL;
  assign wr_evcnt = reg_we && reg_addr == ADDR_EVCNT;
  always_comb begin
    clr_p = wr_status ? reg_wdata[NCH-1:0] : '0;
    clr_o = wr_status ? reg_wdata[OVR_LSB +: NCH] : '0;
    pending_nx = (pending & ~clr_p) | evt;
    overrun_nx = (overrun & ~clr_o) | (evt & pending & ~clr_p);
    evcnt_nx = evcnt;
    for (int i = 0; i < NCH; i++)
      evcnt_nx[i] = wr_evcnt ? EVC_W'(evt[i]) :
                    (evt[i] && evcnt[i] != '1) ? evcnt[i] + EVC_W'(1) : evcnt[i];
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending <= '0;
      overrun <= '0;
      evcnt <= '0;
      enable <= '0;
      pol <= '0;
    end else begin
      pending <= pending_nx;
      overrun <= overrun_nx;
      evcnt <= evcnt_nx;
      if (wr_ctrl) begin
        enable <= reg_wdata[NCH-1:0];
        pol <= reg_wdata[POL_LSB +: NCH];
      end
    end
  end
  always_comb begin
    status_w = '0;
    status_w[NCH-1:0] = pending;
    status_w[OVR_LSB +: NCH] = overrun;
    ctrl_w = '0;
    ctrl_w[NCH-1:0] = enable;
    ctrl_w[POL_LSB +: NCH] = pol;
    reg_rdata = reg_addr == ADDR_STATUS ? status_w :
                reg_addr == ADDR_CTRL   ? ctrl_w :
                reg_addr == ADDR_EVCNT  ? 32'(evcnt) : 32'(sync);
  end
  assign irq = |(pending & enable);
endmodule
